// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// the counter reset value and the default table/history widths.
package bp_pkg;

    localparam int IDX_W_DEF = 6;
    localparam int GHR_W_DEF = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals of the predictor.
interface branch_predictor_if #(
    parameter int GHR_W = 6
);
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_pred;
    logic             upd_taken;
    logic             mispredict;
    logic [31:0]      branch_cnt;
    logic [31:0]      mispred_cnt;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_ghr, upd_pred, upd_taken,
        input  pred_taken, pred_ghr, mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_ghr, upd_pred, upd_taken,
        output pred_taken, pred_ghr, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/sat_ctr2.sv
// Next-state logic of one 2-bit saturating direction counter.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare conditional-branch predictor: PC bits XOR global history index a
// table of 2-bit counters; history is updated only by resolved branches.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int GHR_W = GHR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bus
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0]       pht [ENTRIES];
    logic [GHR_W-1:0] ghr;
    logic [31:0]      br_cnt;
    logic [31:0]      mp_cnt;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_ctr;
    logic [1:0]       upd_ctr_nxt;
    logic             unused_pc_bits;

    function automatic logic [IDX_W-1:0] gshare_idx(input logic [31:0] pc,
                                                    input logic [GHR_W-1:0] hist);
        return pc[IDX_W+1:2] ^ IDX_W'(hist);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign pred_idx    = gshare_idx(bus.pred_pc, ghr);
    assign upd_idx     = gshare_idx(bus.upd_pc, bus.upd_ghr);
    assign upd_ctr     = pht[upd_idx];

    // Reads see the table as it stood before this edge's update.
    assign bus.pred_taken  = pht[pred_idx][1];
    assign bus.pred_ghr    = ghr;
    assign bus.mispredict  = bus.upd_valid & (bus.upd_pred != bus.upd_taken);
    assign bus.branch_cnt  = br_cnt;
    assign bus.mispred_cnt = mp_cnt;

    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                              bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

    sat_ctr2 u_sat_ctr2 (
        .ctr   (upd_ctr),
        .taken (bus.upd_taken),
        .nxt   (upd_ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_RESET;
            ghr    <= '0;
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (bus.upd_valid) begin
            pht[upd_idx] <= upd_ctr_nxt;
            ghr          <= (ghr << 1) | GHR_W'(bus.upd_taken);
            br_cnt       <= sat_inc(br_cnt);
            if (bus.mispredict) mp_cnt <= sat_inc(mp_cnt);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a training/decay vector table plus
// hand-written sequences for reset, same-cycle access, aliasing and saturation.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.GHR_W(6)) bus ();

    branch_predictor #(.IDX_W(6), .GHR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pred_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic [5:0]  upd_ghr;
        logic        upd_pred;
        logic        upd_taken;
        logic        exp_pred;
        logic        exp_misp;
        logic [5:0]  exp_ghr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.upd_valid = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_ghr   = '0;
        bus.upd_pred  = 1'b0;
        bus.upd_taken = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [5:0] h,
                          input logic pr, input logic tk);
        @(negedge clk);
        bus.upd_valid = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_ghr   = h;
        bus.upd_pred  = pr;
        bus.upd_taken = tk;
        step();
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        bus.pred_pc = 32'h40;
        idle_inputs();
        // pred_pc, valid, upd_pc, upd_ghr, pred, taken, exp_pred, exp_misp, exp_ghr
        vecs[0]  = '{32'h40, 1'b1, 32'h40, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01};
        vecs[1]  = '{32'h44, 1'b1, 32'h40, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 6'h03};
        vecs[2]  = '{32'h4C, 1'b1, 32'h40, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 6'h07};
        vecs[3]  = '{32'h5C, 1'b0, 32'hx,  6'hxx, 1'b1, 1'b0, 1'b1, 1'b0, 6'h07};
        vecs[4]  = '{32'h5C, 1'b1, 32'h40, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 6'h0E};
        vecs[5]  = '{32'h78, 1'b1, 32'h40, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 6'h1C};
        vecs[6]  = '{32'h30, 1'b1, 32'h40, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h38};
        vecs[7]  = '{32'hA0, 1'b1, 32'h40, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h30};
        vecs[8]  = '{32'h80, 1'b1, 32'h40, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'h21};
        vecs[9]  = '{32'hC4, 1'b1, 32'h40, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'h03};
        vecs[10] = '{32'h4C, 1'b0, 32'h0,  6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h03};

        // Reset state
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        bus.pred_pc = 32'h40;
        #1;
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pred_ghr", 32'(bus.pred_ghr), 32'd0);
        chk("rst_branch_cnt", bus.branch_cnt, 32'd0);
        chk("rst_mispred_cnt", bus.mispred_cnt, 32'd0);

        // Training, decay and saturation at one counter
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.pred_pc   = vecs[i].pred_pc;
            bus.upd_valid = vecs[i].upd_valid;
            bus.upd_pc    = vecs[i].upd_pc;
            bus.upd_ghr   = vecs[i].upd_ghr;
            bus.upd_pred  = vecs[i].upd_pred;
            bus.upd_taken = vecs[i].upd_taken;
            #1;
            chk($sformatf("vec%0d_pred_taken", i), 32'(bus.pred_taken), 32'(vecs[i].exp_pred));
            chk($sformatf("vec%0d_mispredict", i), 32'(bus.mispredict), 32'(vecs[i].exp_misp));
            step();
            chk($sformatf("vec%0d_ghr", i), 32'(bus.pred_ghr), 32'(vecs[i].exp_ghr));
        end
        chk("table_branch_cnt", bus.branch_cnt, 32'd9);
        chk("table_mispred_cnt", bus.mispred_cnt, 32'd7);

        // Reset with a simultaneous update discards everything
        @(negedge clk);
        rst = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_ghr = 6'h0;
        bus.upd_pred = 1'b0; bus.upd_taken = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bus.pred_pc = 32'h40;
        #1;
        chk("rst2_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst2_pred_ghr", 32'(bus.pred_ghr), 32'd0);
        chk("rst2_branch_cnt", bus.branch_cnt, 32'd0);
        chk("rst2_mispred_cnt", bus.mispred_cnt, 32'd0);
        do_upd(32'h40, 6'h0, 1'b0, 1'b1);
        bus.pred_pc = 32'h44;
        #1;
        chk("rst2_one_taken_weak_t", 32'(bus.pred_taken), 32'd1);

        // Same-cycle read and update of one entry
        do_reset();
        bus.pred_pc = 32'h80;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h80; bus.upd_ghr = 6'h0;
        bus.upd_pred = 1'b0; bus.upd_taken = 1'b1;
        #1;
        chk("same_cycle_old_value", 32'(bus.pred_taken), 32'd0);
        step();
        chk("same_cycle_other_idx", 32'(bus.pred_taken), 32'd0);
        bus.pred_pc = 32'h84;
        #1;
        chk("same_cycle_new_value", 32'(bus.pred_taken), 32'd1);
        @(negedge clk);
        idle_inputs();

        // Aliasing: history selects a different entry for the same PC
        do_reset();
        do_upd(32'h40, 6'h01, 1'b0, 1'b1);
        bus.pred_pc = 32'h40;
        #1;
        chk("alias_idx11_ghr1", 32'(bus.pred_taken), 32'd1);
        bus.pred_pc = 32'h44;
        #1;
        chk("alias_idx10_ghr1", 32'(bus.pred_taken), 32'd0);
        for (int i = 0; i < 6; i++) do_upd(32'h0, 6'h0, 1'b0, 1'b0);
        chk("alias_ghr_cleared", 32'(bus.pred_ghr), 32'd0);
        bus.pred_pc = 32'h44;
        #1;
        chk("alias_pc44_ghr0", 32'(bus.pred_taken), 32'd1);
        bus.pred_pc = 32'h40;
        #1;
        chk("alias_pc40_ghr0", 32'(bus.pred_taken), 32'd0);

        // Statistics counters saturate instead of wrapping
        do_reset();
        force dut.br_cnt = 32'hFFFF_FFFE;
        force dut.mp_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt;
        release dut.mp_cnt;
        #1;
        chk("sat_preload_branch", bus.branch_cnt, 32'hFFFF_FFFE);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.upd_valid = 1'b1; bus.upd_pc = 32'h100; bus.upd_ghr = 6'h0;
            bus.upd_pred = 1'b1; bus.upd_taken = 1'b0;
            #1;
            chk($sformatf("sat_mispredict%0d", i), 32'(bus.mispredict), 32'd1);
            step();
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sat_branch_cnt", bus.branch_cnt, 32'hFFFF_FFFF);
        chk("sat_mispred_cnt", bus.mispred_cnt, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
